// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Provides the state encoding and a width helper for the iteration counter.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration.
// Shifts the next dividend bit into the partial remainder and subtracts the divisor if it fits.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_prem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_prem,
    output logic             o_qbit
);

    logic [WIDTH:0]   w_shifted;
    logic             w_borrow;
    logic [WIDTH-1:0] w_diff;

    assign w_shifted = {i_prem, i_bit};
    assign w_borrow  = (w_shifted < {1'b0, i_divisor});
    // When no borrow occurs the true difference is below the divisor, so W bits are enough.
    assign w_diff    = w_shifted[WIDTH-1:0] - i_divisor;
    assign o_prem    = w_borrow ? w_shifted[WIDTH-1:0] : w_diff;
    assign o_qbit    = ~w_borrow;

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, with start/busy/done handshake.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero
);

    localparam int CNT_W = clog2(2*WIDTH + 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_dvd_sh;
    logic [2*WIDTH-1:0] r_q;
    logic [WIDTH-1:0]   r_prem;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_dbz;

    logic [WIDTH-1:0]   w_prem_next;
    logic               w_qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_prem    (r_prem),
        .i_bit     (r_dvd_sh[2*WIDTH-1]),
        .i_divisor (r_dvs),
        .o_prem    (w_prem_next),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dvs <= divisor;
                        if (divisor != '0) begin
                            r_dvd_sh <= dividend;
                            r_prem   <= '0;
                            r_q      <= '0;
                            r_cnt    <= CNT_W'(2*WIDTH);
                            r_dbz    <= 1'b0;
                            busy     <= 1'b1;
                            r_state  <= ST_CALC;
                        end else begin
                            // Divide by zero skips CALC; results are staged and published in DONE.
                            r_q     <= '1;
                            r_prem  <= dividend[WIDTH-1:0];
                            r_dbz   <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_CALC: begin
                    r_dvd_sh <= r_dvd_sh << 1;
                    r_prem   <= w_prem_next;
                    r_q      <= {r_q[2*WIDTH-2:0], w_qbit};
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        busy    <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done        <= 1'b1;
                    quotient    <= r_q;
                    remainder   <= r_prem;
                    div_by_zero <= r_dbz;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider with a scoreboard of expected results.
module tb_seq_divider;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [2*W-1:0] quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;

    typedef struct {
        logic [2*W-1:0] q;
        logic [W-1:0]   r;
        logic           dbz;
        int             lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input logic [2*W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q   = '1;
            e.r   = a[W-1:0];
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
            e.lat = 2*W + 1;
        end
        return e;
    endfunction

    // Drives one request; returns 1 ns after the accepting edge with operands scrambled.
    task automatic issue(input logic [2*W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        check("busy_after_accept", busy, (b != 0));
    endtask

    // Waits for done (n0 edges already elapsed since acceptance) and scores the result.
    task automatic wait_done(input string tag, input int n0);
        exp_t e;
        int   n;
        check({tag, "_pending"}, (sb.size() > 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        n = n0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
        check({tag, "_latency"}, done ? n : 0, e.lat);
        check({tag, "_quotient"}, quotient, e.q);
        check({tag, "_remainder"}, remainder, e.r);
        check({tag, "_dbz"}, div_by_zero, e.dbz);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int stray;
        logic [2*W-1:0] a;
        logic [W-1:0]   b;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(16'd19635, 8'd119);
        wait_done("p19635_119", 0);
        issue(16'd1000, 8'd7);
        wait_done("p1000_7", 0);
        issue(16'd65535, 8'd255);
        wait_done("p65535_255", 0);
        issue(16'd200, 8'd0);
        wait_done("p200_0", 0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_quotient", quotient, 16'hFFFF);
        check("hold_dbz", div_by_zero, 1);

        // Second request during CALC must be dropped.
        issue(16'd500, 8'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        dividend = 16'd9;
        divisor  = 8'd9;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("p500_3", 5);
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) stray++;
        end
        check("ignored_start_activity", stray, 0);
        check("ignored_start_quotient", quotient, 166);

        // Reset in the middle of a calculation.
        issue(16'd19635, 8'd119);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        void'(sb.pop_back());
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'd100, 8'd10);
        wait_done("p100_10", 0);

        // Start held high: next op accepted in the IDLE cycle after DONE.
        @(negedge clk);
        dividend = 16'd1234;
        divisor  = 8'd56;
        start    = 1'b1;
        sb.push_back(model(16'd1234, 8'd56));
        sb.push_back(model(16'd1234, 8'd56));
        @(posedge clk);
        #1;
        wait_done("held_first", 0);
        check("held_reaccept_busy", busy, 1);
        start = 1'b0;
        wait_done("held_second", 0);

        for (int k = 0; k < 300; k++) begin
            a = 16'($urandom_range(0, 65535));
            b = (k % 4 == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(1, 255));
            issue(a, b);
            wait_done("rand", 0);
            check("rand_invariant", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            check("rand_rem_lt_div", (remainder < b), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
